mcpu_soc_ltc_rdarb: RTL and testbench
=====================================

# mcpu_soc_ltc_rdarb

Two-requester read arbiter for the LTC 128-bit read port. It shares one LTC read interface between the video scanout fetcher (port V) and a secondary DMA/debug reader (port D). Port V has priority when it signals FIFO urgency, and port D has a starvation guarantee. Responses from the LTC return in order and are routed back to the issuing port through an in-order tag queue. It sits between the requesters and the LTC in the SoC top level.

## Interface
Parameters:
- OUTSTANDING, 8 — maximum number of granted reads without a response, including the one held in the output register; 2..16.
- STARVE_LIMIT, 32 — number of consecutive cycles port D may wait with `d_re` high and no grant before it is forced a grant.

Ports:
- `clkrst_core_clk` in 1 — single clock, all logic on its rising edge.
- `clkrst_core_rst_n` in 1 — asynchronous active-low reset.
- `video2arb_re` in 1 — port V read request; held with its address while `arb2video_stall` is high.
- `video2arb_addr` in [28:7] — port V 128-byte line address.
- `video2arb_urgent` in 1 — port V FIFO below watermark; raises V priority.
- `arb2video_stall` out 1 — V request not accepted this cycle.
- `arb2video_rvalid` out 1 — response beat belongs to V.
- `arb2video_rdata` out 128 — response data (shared bus).
- `dma2arb_re`, `dma2arb_addr`, `arb2dma_stall`, `arb2dma_rvalid`, `arb2dma_rdata` — same as the V port; no urgent input.
- `arb2ltc_re` out 1 — registered request to the LTC.
- `arb2ltc_addr` out [28:7] — registered address to the LTC.
- `ltc2arb_stall` in 1 — LTC not accepting; `arb2ltc_re`/`arb2ltc_addr` held.
- `ltc2arb_rvalid` in 1 — in-order response beat.
- `ltc2arb_rdata` in 128 — response data.
- `arb_err` out 1 — sticky flag: response arrived with no outstanding tag.

## Operation
- **Acceptance.** A request is accepted in a cycle where `re`=1 and its `stall`=0.
- **Output register.** `arb2ltc_re`/`arb2ltc_addr` form a one-entry register.
  - It can load when empty, or when `ltc2arb_stall`=0 in this cycle.
  - A load writes the granted request. With no grant, `arb2ltc_re` is cleared when the current request is accepted downstream.
- **Grant eligibility.** A grant occurs only if the register can load and the outstanding count is below OUTSTANDING.
  - A same-cycle pop does not free a slot.
  - When no grant is possible, both stalls are 1.
- **Priority order**, highest first:
  1. Port D starved (`starve_cnt` ≥ STARVE_LIMIT) and `dma2arb_re`.
  2. `video2arb_urgent` and `video2arb_re`.
  3. Round-robin between active requesters. `rr_last` records the last grantee, and the other port wins ties.
- **Stall outputs** are combinational. The grantee sees stall=0. Any other requesting port sees stall=1. A non-requesting port's stall is don't-care, driven 1.
- **starve_cnt** saturates at STARVE_LIMIT.
  - Increments each cycle `dma2arb_re`=1 and D is not granted.
  - Clears on a D grant or when `dma2arb_re`=0.
- **Tag queue.** On each grant, push the owner bit (0=V, 1=D) into an OUTSTANDING-deep FIFO and increment the count.
  - On `ltc2arb_rvalid`, pop the head and route the beat: `arb2video_rvalid` = rvalid & head==0; `arb2dma_rvalid` = rvalid & head==1.
  - `ltc2arb_rdata` is forwarded to both rdata outputs unmodified.
  - Push and pop in the same cycle leave the count unchanged. Pointers wrap modulo OUTSTANDING.
- **Response with empty queue.** Drop the beat: both rvalids 0, count unchanged, `arb_err` set. `arb_err` clears only on reset.
- **Reset values:** `arb2ltc_re`=0, `arb2ltc_addr`=0, `arb_err`=0, count=0, `starve_cnt`=0, `rr_last`=D (so V wins the first tie).
  - Reset mid-operation discards all tags. Later orphan responses set `arb_err`.

## Timing
- Accept in cycle N → `arb2ltc_re`=1 with that address from cycle N+1.
- `arb2ltc_re`/`arb2ltc_addr` remain stable while `ltc2arb_stall`=1.
- Back-to-back acceptances are possible at one per cycle while `ltc2arb_stall`=0.
- Response routing is zero-latency combinational: `ltc2arb_rvalid` in cycle M → the owner rvalid and rdata are valid in cycle M.
- Stall outputs depend combinationally on `ltc2arb_stall`, the requests, `urgent`, the count and `starve_cnt`, with no registered lag.

## Test plan
- **Single port V:** V reads 0x200..0x207 back-to-back with the LTC never stalling.
  - Required: 8 acceptances in 8 cycles, `arb2ltc_addr` sequence 0x200..0x207 starting one cycle later.
  - Required: 8 responses all on `arb2video_rvalid`, none on `arb2dma_rvalid`.
- **Round-robin:** both ports request continuously, `urgent`=0.
  - Required: grants alternate V,D,V,D; first grant goes to V after reset.
  - Required: responses route in that same alternating order with interleaved rdata.
- **Urgency and starvation:** both request, `urgent`=1 continuously, STARVE_LIMIT=32.
  - Required: V wins 32 consecutive grants, then D gets 1 grant, then `starve_cnt` is 0 and V again.
- **Outstanding limit:** LTC never returns rvalid, OUTSTANDING=8.
  - Required: exactly 8 grants, then both stalls stay 1.
  - Then one `ltc2arb_rvalid` pulse → exactly one further grant, no earlier than the cycle after the pop.
- **Downstream stall:** `ltc2arb_stall`=1 for 5 cycles with a request held.
  - Required: `arb2ltc_addr` unchanged for those cycles and both requesters stalled.
  - Required: on release, the held request is accepted, the next grant loads the same cycle, and nothing is lost or duplicated.
- **Orphan response and reset:** assert reset with 3 reads outstanding, then deliver 3 rvalid beats.
  - Required: no owner rvalid asserts and `arb_err`=1 after the first beat.
  - Required: `arb_err` returns to 0 only after the next reset.

Source files
------------

// File: rtl/mcpu_soc_ltc_rdarb.sv
// -----------------------------------------------------------------------------
// mcpu_soc_ltc_rdarb
//
// Purpose: shares one LTC 128-bit read port between the video scanout fetcher
// (port V) and a DMA/debug reader (port D). V gets priority while its FIFO is
// urgent. D is forced a grant after waiting STARVE_LIMIT cycles. Responses come
// back in order and are steered to the issuing port by a FIFO of owner bits.
//
// Handshake: a requester holds re and addr stable until it sees stall=0 in a
// cycle with re=1; that cycle is the acceptance. Towards the LTC, arb2ltc_re
// and arb2ltc_addr are held while ltc2arb_stall=1 and are accepted in a cycle
// with arb2ltc_re=1 and ltc2arb_stall=0.
//
// Ports:
//   clkrst_core_clk, clkrst_core_rst_n  clock, async active-low reset
//   video2arb_re/addr/urgent            port V request
//   arb2video_stall/rvalid/rdata        port V stall and response
//   dma2arb_re/addr                     port D request
//   arb2dma_stall/rvalid/rdata          port D stall and response
//   arb2ltc_re/addr                     registered request to the LTC
//   ltc2arb_stall/rvalid/rdata          LTC back-pressure and in-order response
//   arb_err                             sticky: response with no outstanding tag
// -----------------------------------------------------------------------------
module mcpu_soc_ltc_rdarb #(
   parameter int OUTSTANDING  = 8,
   parameter int STARVE_LIMIT = 32
) (
   input  logic          clkrst_core_clk,
   input  logic          clkrst_core_rst_n,
   input  logic          video2arb_re,
   input  logic [28:7]   video2arb_addr,
   input  logic          video2arb_urgent,
   output logic          arb2video_stall,
   output logic          arb2video_rvalid,
   output logic [127:0]  arb2video_rdata,
   input  logic          dma2arb_re,
   input  logic [28:7]   dma2arb_addr,
   output logic          arb2dma_stall,
   output logic          arb2dma_rvalid,
   output logic [127:0]  arb2dma_rdata,
   output logic          arb2ltc_re,
   output logic [28:7]   arb2ltc_addr,
   input  logic          ltc2arb_stall,
   input  logic          ltc2arb_rvalid,
   input  logic [127:0]  ltc2arb_rdata,
   output logic          arb_err
);

   localparam int PW = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
   localparam int CW = $clog2(OUTSTANDING + 1);
   localparam int SW = $clog2(STARVE_LIMIT + 1);
   localparam logic [PW-1:0] PTR_LAST = PW'(OUTSTANDING - 1);
   localparam logic [CW-1:0] CNT_MAX  = CW'(OUTSTANDING);
   localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

   logic          tag_q [OUTSTANDING];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] out_cnt;
   logic [SW-1:0] starve_cnt;
   logic          rr_last;      // 0 = V granted last, 1 = D granted last

   logic can_load;
   logic grant_ok;
   logic d_starved;
   logic gnt_v;
   logic gnt_d;
   logic grant;
   logic q_empty;
   logic head;
   logic pop;

   // The output register may load when empty or when its current content is
   // being taken by the LTC this cycle. The slot check uses the registered
   // count only, so a pop in the same cycle does not open a slot until the next.
   assign can_load  = !arb2ltc_re || !ltc2arb_stall;
   assign grant_ok  = can_load && (out_cnt < CNT_MAX);
   assign d_starved = (starve_cnt >= STARVE_MAX);

   always_comb begin
      gnt_v = 1'b0;
      gnt_d = 1'b0;
      if (grant_ok) begin
         if (d_starved && dma2arb_re) begin
            gnt_d = 1'b1;
         end else if (video2arb_urgent && video2arb_re) begin
            gnt_v = 1'b1;
         end else if (video2arb_re && dma2arb_re) begin
            // Tie: the port that did not win last time goes now.
            gnt_v = rr_last;
            gnt_d = !rr_last;
         end else begin
            gnt_v = video2arb_re;
            gnt_d = dma2arb_re;
         end
      end
   end

   assign grant           = gnt_v || gnt_d;
   assign arb2video_stall = !gnt_v;
   assign arb2dma_stall   = !gnt_d;

   // Response steering: the head tag names the owner of the oldest read.
   assign q_empty          = (out_cnt == '0);
   assign head             = tag_q[rd_ptr];
   assign pop              = ltc2arb_rvalid && !q_empty;
   assign arb2video_rvalid = pop && !head;
   assign arb2dma_rvalid   = pop && head;
   assign arb2video_rdata  = ltc2arb_rdata;
   assign arb2dma_rdata    = ltc2arb_rdata;

   // Tag storage needs no reset: entries are only read while counted valid.
   always_ff @(posedge clkrst_core_clk) begin
      if (grant) begin
         tag_q[wr_ptr] <= gnt_d;
      end
   end

   always_ff @(posedge clkrst_core_clk or negedge clkrst_core_rst_n) begin
      if (!clkrst_core_rst_n) begin
         arb2ltc_re   <= 1'b0;
         arb2ltc_addr <= '0;
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         out_cnt      <= '0;
         starve_cnt   <= '0;
         rr_last      <= 1'b1;
         arb_err      <= 1'b0;
      end else begin
         if (grant) begin
            arb2ltc_re   <= 1'b1;
            arb2ltc_addr <= gnt_d ? dma2arb_addr : video2arb_addr;
            wr_ptr       <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
            rr_last      <= gnt_d;
         end else if (!ltc2arb_stall) begin
            arb2ltc_re   <= 1'b0;
         end

         if (pop) begin
            rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
         end

         if (grant && !pop) begin
            out_cnt <= out_cnt + 1'b1;
         end else if (!grant && pop) begin
            out_cnt <= out_cnt - 1'b1;
         end

         if (ltc2arb_rvalid && q_empty) begin
            arb_err <= 1'b1;
         end

         if (dma2arb_re && !gnt_d) begin
            if (starve_cnt < STARVE_MAX) begin
               starve_cnt <= starve_cnt + 1'b1;
            end
         end else begin
            starve_cnt <= '0;
         end
      end
   end

endmodule

// File: tb/tb_mcpu_soc_ltc_rdarb.sv
// -----------------------------------------------------------------------------
// tb_mcpu_soc_ltc_rdarb
//
// Directed bench for the LTC read arbiter. Each step: advance to 1 ns after
// the rising edge, drive the LTC model and requests, wait 1 ns, then compare.
// The LTC model either answers every accepted request in the same cycle
// (auto_rsp) or only on an explicit one-cycle pulse. Expected grants are
// written by hand per step; each expected grant pushes {owner, addr} into
// exp_q and each response beat pops and checks it.
// -----------------------------------------------------------------------------
module tb_mcpu_soc_ltc_rdarb;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          v_re;
   logic [28:7]   v_addr;
   logic          v_urgent;
   logic          v_stall;
   logic          v_rvalid;
   logic [127:0]  v_rdata;
   logic          d_re;
   logic [28:7]   d_addr;
   logic          d_stall;
   logic          d_rvalid;
   logic [127:0]  d_rdata;
   logic          ltc_re;
   logic [28:7]   ltc_addr;
   logic          ltc_stall;
   logic          ltc_rvalid;
   logic [127:0]  ltc_rdata;
   logic          err;

   mcpu_soc_ltc_rdarb #(.OUTSTANDING(8), .STARVE_LIMIT(32)) dut (
      .clkrst_core_clk   (clk),
      .clkrst_core_rst_n (rst_n),
      .video2arb_re      (v_re),
      .video2arb_addr    (v_addr),
      .video2arb_urgent  (v_urgent),
      .arb2video_stall   (v_stall),
      .arb2video_rvalid  (v_rvalid),
      .arb2video_rdata   (v_rdata),
      .dma2arb_re        (d_re),
      .dma2arb_addr      (d_addr),
      .arb2dma_stall     (d_stall),
      .arb2dma_rvalid    (d_rvalid),
      .arb2dma_rdata     (d_rdata),
      .arb2ltc_re        (ltc_re),
      .arb2ltc_addr      (ltc_addr),
      .ltc2arb_stall     (ltc_stall),
      .ltc2arb_rvalid    (ltc_rvalid),
      .ltc2arb_rdata     (ltc_rdata),
      .arb_err           (err)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   // ---------------- scoreboard state ----------------
   logic [22:0]  exp_q[$];   // {owner (0=V,1=D), addr}
   int           n_chk  = 0;
   int           n_fail = 0;
   int           rsp_v  = 0;
   int           rsp_d  = 0;
   bit           auto_rsp   = 1'b0;
   bit           ltc_stall_b = 1'b0;
   bit           pulse_rsp  = 1'b0;
   logic [21:0]  pulse_addr = '0;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
      ltc_stall = ltc_stall_b;
      if (pulse_rsp) begin
         ltc_rvalid = 1'b1;
         ltc_rdata  = {106'b0, pulse_addr};
         pulse_rsp  = 1'b0;
      end else if (auto_rsp) begin
         ltc_rvalid = ltc_re && !ltc_stall_b;
         ltc_rdata  = {106'b0, ltc_addr};
      end else begin
         ltc_rvalid = 1'b0;
      end
   endtask

   task automatic check_rsp(input string tag);
      logic [22:0] e;
      if (v_rvalid) rsp_v++;
      if (d_rvalid) rsp_d++;
      if (ltc_rvalid && exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk({tag, "_vrvalid"}, v_rvalid, !e[22]);
         chk({tag, "_drvalid"}, d_rvalid, e[22]);
         chk({tag, "_vrdata"}, v_rdata, {106'b0, e[21:0]});
         chk({tag, "_drdata"}, d_rdata, {106'b0, e[21:0]});
      end else begin
         chk({tag, "_vrvalid0"}, v_rvalid, 1'b0);
         chk({tag, "_drvalid0"}, d_rvalid, 1'b0);
      end
   endtask

   // exp_owner: 0 = V granted, 1 = D granted, 2 = nobody granted
   task automatic step(input bit vr, input bit dr, input bit urg,
                       input logic [21:0] va, input logic [21:0] da,
                       input int exp_owner, input string tag);
      tick();
      v_re = vr; d_re = dr; v_urgent = urg; v_addr = va; d_addr = da;
      #1;
      chk({tag, "_vstall"}, v_stall, exp_owner != 0);
      chk({tag, "_dstall"}, d_stall, exp_owner != 1);
      check_rsp(tag);
      if (exp_owner == 0) exp_q.push_back({1'b0, va});
      if (exp_owner == 1) exp_q.push_back({1'b1, da});
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      v_re = 1'b0; d_re = 1'b0; v_urgent = 1'b0;
      ltc_rvalid = 1'b0; ltc_stall_b = 1'b0; ltc_stall = 1'b0;
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   // ---------------- directed sequence ----------------
   initial begin : main
      logic [21:0] va;
      logic [21:0] da;
      int          own;

      rst_n = 1'b0;
      v_re = 1'b0; v_addr = '0; v_urgent = 1'b0;
      d_re = 1'b0; d_addr = '0;
      ltc_stall = 1'b0; ltc_rvalid = 1'b0; ltc_rdata = '0;
      #1;
      chk("rst_ltc_re", ltc_re, 1'b0);
      chk("rst_ltc_addr", ltc_addr, 22'h0);
      chk("rst_err", err, 1'b0);
      chk("rst_vstall", v_stall, 1'b1);
      chk("rst_dstall", d_stall, 1'b1);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Single port V, back-to-back, LTC answers immediately
      auto_rsp = 1'b1;
      for (int i = 0; i < 8; i++) begin
         step(1'b1, 1'b0, 1'b0, 22'h200 + 22'(i), 22'h0, 0, "single");
         chk("single_ltc_re", ltc_re, i > 0);
         if (i > 0) chk("single_ltc_addr", ltc_addr, 22'h200 + 22'(i - 1));
      end
      step(1'b0, 1'b0, 1'b0, 22'h0, 22'h0, 2, "single_tail");
      chk("single_last_addr", ltc_addr, 22'h207);
      step(1'b0, 1'b0, 1'b0, 22'h0, 22'h0, 2, "single_idle");
      chk("single_ltc_re_off", ltc_re, 1'b0);
      chk("single_rsp_v", rsp_v, 8);
      chk("single_rsp_d", rsp_d, 0);
      chk("single_drained", exp_q.size(), 0);

      // Round-robin after reset: V first, then alternate
      do_reset();
      auto_rsp = 1'b1;
      rsp_v = 0; rsp_d = 0;
      va = 22'h100; da = 22'h300;
      for (int k = 0; k < 6; k++) begin
         own = k % 2;
         step(1'b1, 1'b1, 1'b0, va, da, own, "rr");
         if (own == 0) va = va + 1'b1; else da = da + 1'b1;
      end
      step(1'b0, 1'b0, 1'b0, va, da, 2, "rr_tail");
      step(1'b0, 1'b0, 1'b0, va, da, 2, "rr_idle");
      chk("rr_rsp_v", rsp_v, 3);
      chk("rr_rsp_d", rsp_d, 3);
      chk("rr_drained", exp_q.size(), 0);

      // Urgency with starvation guarantee: 32 V, 1 D, 32 V, 1 D
      do_reset();
      auto_rsp = 1'b1;
      va = 22'h1000; da = 22'h2000;
      for (int k = 0; k < 66; k++) begin
         own = (k == 32 || k == 65) ? 1 : 0;
         step(1'b1, 1'b1, 1'b1, va, da, own, "urg");
         if (own == 0) va = va + 1'b1; else da = da + 1'b1;
      end
      step(1'b0, 1'b0, 1'b0, va, da, 2, "urg_tail");
      chk("urg_drained", exp_q.size(), 0);

      // Outstanding limit: LTC never answers until a single pulse
      do_reset();
      auto_rsp = 1'b0;
      for (int k = 0; k < 8; k++) begin
         step(1'b1, 1'b0, 1'b0, 22'h400 + 22'(k), 22'h0, 0, "lim_fill");
      end
      for (int k = 0; k < 4; k++) begin
         step(1'b1, 1'b1, 1'b0, 22'h408, 22'h500, 2, "lim_full");
      end
      chk("lim_ltc_re_off", ltc_re, 1'b0);
      pulse_rsp = 1'b1;
      pulse_addr = 22'h400;
      step(1'b1, 1'b1, 1'b0, 22'h408, 22'h500, 2, "lim_pop");
      step(1'b1, 1'b1, 1'b0, 22'h408, 22'h500, 1, "lim_regrant");
      step(1'b1, 1'b1, 1'b0, 22'h408, 22'h501, 2, "lim_full2");
      chk("lim_ltc_addr", ltc_addr, 22'h500);

      // Downstream stall holds the output register
      do_reset();
      auto_rsp = 1'b1;
      step(1'b1, 1'b0, 1'b0, 22'h600, 22'h0, 0, "ds_first");
      ltc_stall_b = 1'b1;
      for (int k = 0; k < 5; k++) begin
         step(1'b1, 1'b1, 1'b0, 22'h601, 22'h700, 2, "ds_hold");
         chk("ds_hold_re", ltc_re, 1'b1);
         chk("ds_hold_addr", ltc_addr, 22'h600);
      end
      ltc_stall_b = 1'b0;
      step(1'b1, 1'b1, 1'b0, 22'h601, 22'h700, 1, "ds_release");
      chk("ds_release_addr", ltc_addr, 22'h600);
      step(1'b1, 1'b0, 1'b0, 22'h601, 22'h701, 0, "ds_next");
      chk("ds_next_addr", ltc_addr, 22'h700);
      step(1'b0, 1'b0, 1'b0, 22'h601, 22'h701, 2, "ds_tail");
      chk("ds_tail_addr", ltc_addr, 22'h601);
      step(1'b0, 1'b0, 1'b0, 22'h0, 22'h0, 2, "ds_idle");
      chk("ds_idle_re", ltc_re, 1'b0);
      chk("ds_drained", exp_q.size(), 0);

      // Orphan responses after a reset with reads in flight
      do_reset();
      auto_rsp = 1'b0;
      for (int k = 0; k < 3; k++) begin
         step(1'b1, 1'b0, 1'b0, 22'h800 + 22'(k), 22'h0, 0, "orph_issue");
      end
      step(1'b0, 1'b0, 1'b0, 22'h0, 22'h0, 2, "orph_drain");
      rst_n = 1'b0;
      exp_q.delete();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      #1;
      chk("orph_rst_re", ltc_re, 1'b0);
      chk("orph_rst_err", err, 1'b0);
      for (int k = 0; k < 3; k++) begin
         pulse_rsp = 1'b1;
         pulse_addr = 22'h800 + 22'(k);
         step(1'b0, 1'b0, 1'b0, 22'h0, 22'h0, 2, "orph_beat");
         chk("orph_err", err, k > 0);
      end
      step(1'b0, 1'b0, 1'b0, 22'h0, 22'h0, 2, "orph_after");
      chk("orph_err_sticky", err, 1'b1);
      step(1'b0, 1'b0, 1'b0, 22'h0, 22'h0, 2, "orph_after2");
      chk("orph_err_sticky2", err, 1'b1);
      do_reset();
      #1;
      chk("orph_err_cleared", err, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
